axi_burst_slave_mem: RTL

- AXI4-style burst memory responder, the slave end of the DMA master's read (AR/R) and write (AW/W/B) channels, in the sys_clk domain.
- Holds a word-addressed memory array.
- Serves INCR bursts: one word per beat, address +1 per beat.
- Read and write channels run independently and concurrently; each has its own FSM.

---
 rtl/axi_pkg.sv | 21 ++
 rtl/slave_mem_1w1r.sv | 41 ++++
 rtl/axi_burst_slave_mem.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI burst slave memory.
//   RESP_OKAY / RESP_SLVERR : B/R channel response codes
//   r_state_t               : read channel FSM states
//   w_state_t               : write channel FSM states
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } r_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

endpackage

// File: rtl/slave_mem_1w1r.sv
// Word-addressed memory with one write port and one registered read port.
// A read and a write to the same index in the same cycle return the old
// contents (read-before-write). The array itself is not reset; only the
// read data register is.
//   sys_clk, sys_rst_n : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr         : read request, data appears on rd_data next cycle
//   rd_data               : registered read data, held while rd_en is low
module slave_mem_1w1r #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 6
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_BITS-1:0]  wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_BITS-1:0]  rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI4-style INCR burst memory responder (slave side of AR/R and AW/W/B).
// One word per beat, word address +1 per beat, address wraps modulo the
// memory depth. Read and write channels have independent FSMs.
//   sys_clk, sys_rst_n          : clock, async active-low reset
//   araddr/arlen/arvalid/arready: read address channel
//   rdata/rresp/rlast/rvalid/rready : read data channel (rresp always OKAY)
//   awaddr/awlen/awvalid/awready: write address channel
//   wdata/wlast/wvalid/wready   : write data channel
//   bresp/bvalid/bready         : write response (SLVERR on wlast mismatch)
//
// state  | meaning
// R_IDLE | arready high, waiting for a read burst request
// R_BURST| presenting read beats, rdata/rlast held while stalled
// W_IDLE | awready high, waiting for a write burst request
// W_DATA | wready high, writing one word per accepted beat
// W_RESP | bvalid high, holding bresp until bready
module axi_burst_slave_mem
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int MEM_DEPTH_LOG2  = 6
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic [ADDR_WIDTH-1:0]      araddr,
    input  logic [BURST_LEN_WIDTH-1:0] arlen,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [DATA_WIDTH-1:0]      rdata,
    output logic [1:0]                 rresp,
    output logic                       rlast,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [ADDR_WIDTH-1:0]      awaddr,
    input  logic [BURST_LEN_WIDTH-1:0] awlen,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [DATA_WIDTH-1:0]      wdata,
    input  logic                       wlast,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready
);

    r_state_t                   r_state;
    logic [ADDR_WIDTH-1:0]      rd_ptr;
    logic [BURST_LEN_WIDTH-1:0] rd_cnt;
    logic                       ar_hs;
    logic                       r_hs;
    logic                       rd_en;
    logic [MEM_DEPTH_LOG2-1:0]  rd_idx;

    w_state_t                   w_state;
    logic [ADDR_WIDTH-1:0]      wr_ptr;
    logic [BURST_LEN_WIDTH-1:0] wr_cnt;
    logic                       aw_hs;
    logic                       w_hs;
    logic                       cnt_done;
    logic                       w_end;

    assign rresp = RESP_OKAY;

    assign ar_hs = (r_state == R_IDLE) && arvalid && arready;
    assign r_hs  = (r_state == R_BURST) && rvalid && rready;

    // A load is issued for the first beat on AR accept and for each
    // following beat when the current one is taken; the memory register
    // then becomes rdata, so rdata stays put during stalls.
    assign rd_en  = ar_hs || (r_hs && !rlast);
    assign rd_idx = ar_hs ? araddr[MEM_DEPTH_LOG2-1:0] : rd_ptr[MEM_DEPTH_LOG2-1:0];

    assign aw_hs    = (w_state == W_IDLE) && awvalid && awready;
    assign w_hs     = (w_state == W_DATA) && wvalid && wready;
    assign cnt_done = (wr_cnt == '0);
    assign w_end    = cnt_done || wlast;

    slave_mem_1w1r #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_BITS  (MEM_DEPTH_LOG2)
    ) u_mem (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .wr_en     (w_hs),
        .wr_addr   (wr_ptr[MEM_DEPTH_LOG2-1:0]),
        .wr_data   (wdata),
        .rd_en     (rd_en),
        .rd_addr   (rd_idx),
        .rd_data   (rdata)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rd_ptr  <= '0;
            rd_cnt  <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        rd_ptr  <= araddr + ADDR_WIDTH'(1);
                        rd_cnt  <= arlen;
                        rvalid  <= 1'b1;
                        rlast   <= (arlen == '0);
                        arready <= 1'b0;
                        r_state <= R_BURST;
                    end else begin
                        arready <= 1'b1;
                    end
                end
                R_BURST: begin
                    if (r_hs) begin
                        if (rlast) begin
                            rvalid  <= 1'b0;
                            rlast   <= 1'b0;
                            arready <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
                            rd_cnt <= rd_cnt - BURST_LEN_WIDTH'(1);
                            rlast  <= (rd_cnt == BURST_LEN_WIDTH'(1));
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            wr_ptr  <= '0;
            wr_cnt  <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_ptr  <= awaddr;
                        wr_cnt  <= awlen;
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
                        if (w_end) begin
                            // Burst ends on whichever comes first; any
                            // disagreement between count and wlast is an error.
                            wready  <= 1'b0;
                            bvalid  <= 1'b1;
                            bresp   <= (cnt_done != wlast) ? RESP_SLVERR : RESP_OKAY;
                            w_state <= W_RESP;
                        end else begin
                            wr_cnt <= wr_cnt - BURST_LEN_WIDTH'(1);
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        bresp   <= RESP_OKAY;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule
